// File: rtl/sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sram_bus_arbiter
//
// Purpose:
//   Shares one downstream SRAM-like port (req / addr_ok / data_ok) between
//   the instruction requester (fetch) and the data requester (memory stage).
//   Each address phase is arbitrated, the owner of every accepted request is
//   remembered in an in-order owner FIFO, and each data_ok / rdata is steered
//   back to whichever requester issued the matching request.
//
// Ports:
//   clk_i, rstn_i           clock, synchronous active-low reset
//   inst_*_i / inst_*_o     instruction requester request, attributes and
//                           addr_ok / data_ok / rdata handshakes
//   data_*_i / data_*_o     data requester, same shape as inst_*
//   mem_*_o / mem_*_i       downstream request, attributes and handshakes
//   proto_err_o             sticky: mem_data_ok arrived with no request in
//                           flight
// ----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [3:0]  inst_wstrb_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [3:0]  data_wstrb_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_size_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_addr_ok_i,
    input  logic        mem_data_ok_i,
    input  logic [31:0] mem_rdata_i,

    output logic        proto_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lockState_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } grant_e;

    lockState_e         lockState_q, lockState_d;
    grant_e             grant;

    logic               ownerFifo_q [MAX_OUTSTANDING];
    logic               ownerFifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   headPtr_q, headPtr_d;
    logic [PTR_W-1:0]   tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STV_W-1:0]   starveCnt_q, starveCnt_d;
    logic               protoErr_q, protoErr_d;

    logic               accept;
    logic               respValid;
    logic               fifoEmpty;

    // Pointer increment that wraps at the FIFO depth, which need not be a
    // power of two.
    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifoEmpty = (count_q == '0);

    // Grant selection. A pending lock pins the grant so downstream sees stable
    // request fields until it accepts. Otherwise a full FIFO blocks everyone,
    // and data wins unless inst has already waited through STARVE_LIMIT data
    // grants. Nothing is granted while reset is asserted.
    always_comb begin
        grant = GRANT_NONE;
        if (!rstn_i) begin
            grant = GRANT_NONE;
        end else if (lockState_q == LOCK_INST) begin
            grant = GRANT_INST;
        end else if (lockState_q == LOCK_DATA) begin
            grant = GRANT_DATA;
        end else if (count_q == CNT_MAX) begin
            grant = GRANT_NONE;
        end else if (data_req_i && ((starveCnt_q < STV_MAX) || !inst_req_i)) begin
            grant = GRANT_DATA;
        end else if (inst_req_i) begin
            grant = GRANT_INST;
        end
    end

    // Downstream request mux: the granted requester's fields pass through,
    // everything is driven to zero when no one holds the grant.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_wr_o    = 1'b0;
        mem_size_o  = '0;
        mem_wstrb_o = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (grant)
            GRANT_INST: begin
                mem_req_o   = inst_req_i;
                mem_wr_o    = inst_wr_i;
                mem_size_o  = inst_size_i;
                mem_wstrb_o = inst_wstrb_i;
                mem_addr_o  = inst_addr_i;
                mem_wdata_o = inst_wdata_i;
            end
            GRANT_DATA: begin
                mem_req_o   = data_req_i;
                mem_wr_o    = data_wr_i;
                mem_size_o  = data_size_i;
                mem_wstrb_o = data_wstrb_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
            default: ;
        endcase
    end

    // Address-phase handshake back to the granted requester only, and
    // zero-latency response routing by the owner at the FIFO head. A response
    // with nothing in flight is swallowed and flagged instead of forwarded.
    assign accept         = mem_req_o & mem_addr_ok_i;
    assign inst_addr_ok_o = accept & (grant == GRANT_INST);
    assign data_addr_ok_o = accept & (grant == GRANT_DATA);

    assign respValid      = rstn_i & mem_data_ok_i & ~fifoEmpty;
    assign inst_data_ok_o = respValid & ~ownerFifo_q[headPtr_q];
    assign data_data_ok_o = respValid &  ownerFifo_q[headPtr_q];
    assign inst_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign proto_err_o    = protoErr_q;

    // Lock next state: a request left waiting for addr_ok pins its owner for
    // the next cycle; any cycle with addr_ok (or no request) unlocks.
    always_comb begin
        lockState_d = LOCK_NONE;
        if (mem_req_o && !mem_addr_ok_i) begin
            lockState_d = (grant == GRANT_DATA) ? LOCK_DATA : LOCK_INST;
        end
    end

    // Owner FIFO, starvation counter and error flag next state. The owner bit
    // is 1 for data, 0 for inst. Push and pop in the same cycle cancel out in
    // the count; the grant gating keeps the count from exceeding the depth.
    always_comb begin
        ownerFifo_d = ownerFifo_q;
        headPtr_d   = headPtr_q;
        tailPtr_d   = tailPtr_q;
        count_d     = count_q;
        starveCnt_d = starveCnt_q;
        protoErr_d  = protoErr_q | (mem_data_ok_i & fifoEmpty);

        if (accept) begin
            ownerFifo_d[tailPtr_q] = (grant == GRANT_DATA);
            tailPtr_d              = incPtr(tailPtr_q);
        end
        if (respValid) begin
            headPtr_d = incPtr(headPtr_q);
        end
        case ({accept, respValid})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (!inst_req_i || (accept && grant == GRANT_INST)) begin
            starveCnt_d = '0;
        end else if (accept && grant == GRANT_DATA && starveCnt_q < STV_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // State registers. Reset drops all in-flight ownership, so any response
    // that still arrives afterwards is reported as a protocol error.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            lockState_q <= LOCK_NONE;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ownerFifo_q[i] <= 1'b0;
            end
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            count_q     <= '0;
            starveCnt_q <= '0;
            protoErr_q  <= 1'b0;
        end else begin
            lockState_q <= lockState_d;
            ownerFifo_q <= ownerFifo_d;
            headPtr_q   <= headPtr_d;
            tailPtr_q   <= tailPtr_d;
            count_q     <= count_d;
            starveCnt_q <= starveCnt_d;
            protoErr_q  <= protoErr_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Self-checking bench for sram_bus_arbiter: a cycle table covering reset,
// lock, full-FIFO blocking and in-order return, hand sequences for
// starvation, protocol error and reset mid-transaction, then randomized
// traffic against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int MAXO  = 2;
    localparam int LIMIT = 4;
    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instReq, instWr;
    logic [1:0]  instSize;
    logic [3:0]  instWstrb;
    logic [31:0] instAddr, instWdata;
    logic        instAddrOk, instDataOk;
    logic [31:0] instRdata;
    logic        dataReq, dataWr;
    logic [1:0]  dataSize;
    logic [3:0]  dataWstrb;
    logic [31:0] dataAddr, dataWdata;
    logic        dataAddrOk, dataDataOk;
    logic [31:0] dataRdata;
    logic        memReq, memWr;
    logic [1:0]  memSize;
    logic [3:0]  memWstrb;
    logic [31:0] memAddr, memWdata;
    logic        memAddrOk, memDataOk;
    logic [31:0] memRdata;
    logic        protoErr;

    int nCompared   = 0;
    int nMismatched = 0;

    sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .inst_req_i(instReq), .inst_wr_i(instWr), .inst_size_i(instSize),
        .inst_wstrb_i(instWstrb), .inst_addr_i(instAddr), .inst_wdata_i(instWdata),
        .inst_addr_ok_o(instAddrOk), .inst_data_ok_o(instDataOk), .inst_rdata_o(instRdata),
        .data_req_i(dataReq), .data_wr_i(dataWr), .data_size_i(dataSize),
        .data_wstrb_i(dataWstrb), .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
        .data_addr_ok_o(dataAddrOk), .data_data_ok_o(dataDataOk), .data_rdata_o(dataRdata),
        .mem_req_o(memReq), .mem_wr_o(memWr), .mem_size_o(memSize),
        .mem_wstrb_o(memWstrb), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_addr_ok_i(memAddrOk), .mem_data_ok_i(memDataOk), .mem_rdata_i(memRdata),
        .proto_err_o(protoErr)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends even if something stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    // One cycle of table stimulus; grant codes are 0 none, 1 inst, 2 data.
    typedef struct packed {
        logic        rstn;
        logic        ir;
        logic        dr;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        expMreq;
        logic [1:0]  expGrant;
        logic        expIaok;
        logic        expDaok;
        logic        expIdok;
        logic        expDdok;
        logic        expPerr;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ir, input logic dr,
                                 input logic aok, input logic dok,
                                 input logic [31:0] rd);
        rstn      = r;
        instReq   = ir;
        dataReq   = dr;
        memAddrOk = aok;
        memDataOk = dok;
        memRdata  = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setFixedAttrs();
        instWr = 1'b0; instSize = 2'd2; instWstrb = 4'h0; instAddr = IA; instWdata = 32'h0;
        dataWr = 1'b1; dataSize = 2'd2; dataWstrb = 4'hF; dataAddr = DA; dataWdata = 32'h1234_5678;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] addrFor(input logic [1:0] g);
        return (g == 2'd1) ? IA : (g == 2'd2) ? DA : 32'h0;
    endfunction

    // Reference model state for the random phase.
    int   mq[$];
    logic mLocked;
    int   mLockOwner;
    int   mStarve;
    logic mPerr;

    initial begin
        string   tag;
        logic [31:0] expAddr;
        logic [6:0]  expAttr;
        int      g;
        logic    expMreq, acc, respOk;
        logic    curIr, curDr;

        setFixedAttrs();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;

        // Cycle table: reset with both requests high, lock on data while inst
        // toggles, inst accept filling the FIFO, blocked request at full,
        // in-order responses and the grant right after the first pop.
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,         1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h0,         1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'hAAAA_0001, 1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'h0280_0C06, 1'b1,2'd1,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'hBBBB_0002, 1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].ir, vecs[i].dr, vecs[i].aok,
                          vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            tag = $sformatf("row%0d", i);
            checkOutput({tag, " memReq"},     {31'b0, memReq},     {31'b0, vecs[i].expMreq});
            checkOutput({tag, " memAddr"},    memAddr,             addrFor(vecs[i].expGrant));
            checkOutput({tag, " instAddrOk"}, {31'b0, instAddrOk}, {31'b0, vecs[i].expIaok});
            checkOutput({tag, " dataAddrOk"}, {31'b0, dataAddrOk}, {31'b0, vecs[i].expDaok});
            checkOutput({tag, " instDataOk"}, {31'b0, instDataOk}, {31'b0, vecs[i].expIdok});
            checkOutput({tag, " dataDataOk"}, {31'b0, dataDataOk}, {31'b0, vecs[i].expDdok});
            checkOutput({tag, " protoErr"},   {31'b0, protoErr},   {31'b0, vecs[i].expPerr});
            if (vecs[i].expIdok) checkOutput({tag, " instRdata"}, instRdata, vecs[i].rdata);
            if (vecs[i].expDdok) checkOutput({tag, " dataRdata"}, dataRdata, vecs[i].rdata);
            nextCycle();
        end

        // Starvation: both requesters always asking, downstream always ready,
        // each previous request answered so the FIFO never fills.
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, (k > 0), 32'(k));
            @(negedge clk);
            checkOutput($sformatf("starve grant%0d memAddr", k), memAddr,
                        (k == 4 || k == 9) ? IA : DA);
            nextCycle();
        end

        // Protocol error: a response with nothing in flight is swallowed and
        // flagged; the flag holds until reset.
        doReset();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("perr instDataOk", {31'b0, instDataOk}, 32'h0);
        checkOutput("perr dataDataOk", {31'b0, dataDataOk}, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("perr set", {31'b0, protoErr}, 32'h1);
        nextCycle();
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("perr sticky", {31'b0, protoErr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("perr cleared", {31'b0, protoErr}, 32'h0);
        nextCycle();

        // Reset mid-transaction: the accepted request's ownership is lost, so
        // its late response is not forwarded and raises the error flag.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midrst accept", {31'b0, instAddrOk}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        checkOutput("midrst instDataOk", {31'b0, instDataOk}, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midrst perr", {31'b0, protoErr}, 32'h1);

        // Randomized traffic against the queue-based reference model. Each
        // requester holds its request and attributes until accepted.
        doReset();
        mq.delete();
        mLocked = 1'b0; mLockOwner = 0; mStarve = 0; mPerr = 1'b0;
        curIr = 1'b0; curDr = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!curIr) begin
                curIr     = ($urandom_range(0, 2) != 0);
                instWr    = $urandom_range(0, 1);
                instSize  = 2'($urandom_range(0, 3));
                instWstrb = 4'($urandom_range(0, 15));
                instAddr  = $urandom;
                instWdata = $urandom;
            end
            if (!curDr) begin
                curDr     = ($urandom_range(0, 2) != 0);
                dataWr    = $urandom_range(0, 1);
                dataSize  = 2'($urandom_range(0, 3));
                dataWstrb = 4'($urandom_range(0, 15));
                dataAddr  = $urandom;
                dataWdata = $urandom;
            end
            applyStimulus(1'b1, curIr, curDr, ($urandom_range(0, 2) != 0),
                          (mq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                          : ($urandom_range(0, 63) == 0),
                          $urandom);

            if (mLocked)                                   g = mLockOwner;
            else if (mq.size() == MAXO)                    g = 0;
            else if (dataReq && (mStarve < LIMIT || !instReq)) g = 2;
            else if (instReq)                              g = 1;
            else                                           g = 0;
            expMreq = (g == 1) ? instReq : (g == 2) ? dataReq : 1'b0;
            expAddr = (g == 1) ? instAddr : (g == 2) ? dataAddr : 32'h0;
            expAttr = (g == 1) ? {instWr, instSize, instWstrb}
                    : (g == 2) ? {dataWr, dataSize, dataWstrb} : 7'h0;
            acc     = expMreq && memAddrOk;
            respOk  = memDataOk && (mq.size() > 0);

            @(negedge clk);
            tag = $sformatf("rand%0d", c);
            checkOutput({tag, " memReq"},  {31'b0, memReq}, {31'b0, expMreq});
            checkOutput({tag, " memAddr"}, memAddr, expAddr);
            checkOutput({tag, " memAttr"}, {25'b0, memWr, memSize, memWstrb}, {25'b0, expAttr});
            checkOutput({tag, " memWdata"}, memWdata,
                        (g == 1) ? instWdata : (g == 2) ? dataWdata : 32'h0);
            checkOutput({tag, " instAddrOk"}, {31'b0, instAddrOk}, {31'b0, acc && g == 1});
            checkOutput({tag, " dataAddrOk"}, {31'b0, dataAddrOk}, {31'b0, acc && g == 2});
            checkOutput({tag, " instDataOk"}, {31'b0, instDataOk},
                        {31'b0, respOk && mq[0] == 1});
            checkOutput({tag, " dataDataOk"}, {31'b0, dataDataOk},
                        {31'b0, respOk && mq[0] == 2});
            checkOutput({tag, " protoErr"}, {31'b0, protoErr}, {31'b0, mPerr});

            if (memDataOk && mq.size() == 0) mPerr = 1'b1;
            if (respOk) void'(mq.pop_front());
            if (acc) mq.push_back(g);
            mLocked    = expMreq && !memAddrOk;
            mLockOwner = g;
            if (!instReq || (acc && g == 1)) mStarve = 0;
            else if (acc && g == 2 && mStarve < LIMIT) mStarve++;
            if (acc && g == 1) curIr = 1'b0;
            if (acc && g == 2) curDr = 1'b0;
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
